// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side frame controller: captures SIPO frames on the rising edge of frame_done,
// validates start/stop/parity, and queues good bytes in a show-ahead FIFO with sticky error flags.
module uart_rx_frame_ctrl #(
    parameter int DEPTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                           baud_clk,
    input  logic                           rst,
    input  logic [10:0]                    frame_in,
    input  logic                           frame_done,
    output logic [7:0]                     rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic                           frame_err,
    output logic                           parity_err,
    output logic                           overrun,
    input  logic                           err_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        STORE    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // bits = {parity, data[7:0]}; mismatch when the overall XOR differs from the selected sense
    function automatic logic parity_bad(input logic [8:0] bits);
        return (^bits) != (PARITY_ODD != 0);
    endfunction

    state_t         state_q, state_d;
    logic           fd_prev_q, fd_prev_d;
    logic [10:0]    latch_q, latch_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           frame_err_q, frame_err_d;
    logic           parity_err_q, parity_err_d;
    logic           overrun_q, overrun_d;
    logic [7:0]     mem_q [DEPTH];

    logic rise, push, pop, full, fe_set, pe_set, ov_set;

    assign rise = frame_done && !fd_prev_q;
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) && rx_ready;

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        ov_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    latch_d = frame_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                fe_set = latch_q[0] || !latch_q[10];
                pe_set = (PARITY_EN != 0) && parity_bad(latch_q[9:1]);
                state_d = (fe_set || pe_set) ? WAIT_LOW : STORE;
            end
            STORE: begin
                // a same-cycle pop frees the slot, so a full FIFO can still accept the byte
                if (!full || pop) push = 1'b1;
                else              ov_set = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!frame_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fd_prev_d    = frame_done;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        frame_err_d  = (frame_err_q  && !err_clr) || fe_set;
        parity_err_d = (parity_err_q && !err_clr) || pe_set;
        overrun_d    = (overrun_q    && !err_clr) || ov_set;
    end

    // history starts at 1 so a frame already presented at reset release is not captured
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fd_prev_q    <= 1'b1;
            latch_q      <= '1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fd_prev_q    <= fd_prev_d;
            latch_q      <= latch_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (push) mem_q[wr_ptr_q] <= latch_q[8:1];
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (DEPTH=4, even parity enabled).
module tb_uart_rx_frame_ctrl;

    logic        baud_clk = 1'b0;
    logic        rst;
    logic [10:0] frame_in;
    logic        frame_done;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  fifo_count;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic        err_clr;

    int tests = 0;
    int fails = 0;

    uart_rx_frame_ctrl #(.DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .baud_clk   (baud_clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_done (frame_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // good frame with even parity: {stop=1, parity, data, start=0}
    function automatic logic [10:0] good(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic send(input logic [10:0] f, input int hold);
        frame_in   = f;
        frame_done = 1'b1;
        repeat (hold) tick();
        frame_done = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; frame_in = '0; frame_done = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_flags", {frame_err, parity_err, overrun}, 0);

        // good frame 0xA5: valid three cycles after the captured edge
        frame_in = 11'b1_0_10100101_0; frame_done = 1'b1;
        tick(); frame_done = 1'b0;
        tick();
        chk("lat_not_yet", rx_valid, 0);
        tick();
        chk("good_valid", rx_valid, 1);
        chk("good_data", rx_data, 8'hA5);
        chk("good_count", fifo_count, 1);
        chk("good_flags", {frame_err, parity_err, overrun}, 0);
        tick();
        chk("hold_data", rx_data, 8'hA5);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        chk("pop_empty", rx_valid, 0);

        // error frames
        send({1'b0, 1'b0, 8'h55, 1'b0}, 1);
        chk("stop_err", frame_err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        send({1'b1, 1'b0, 8'h55, 1'b1}, 1);
        chk("start_err", frame_err, 1);
        chk("start_parity_ok", parity_err, 0);
        send({1'b1, 1'b0, 8'h01, 1'b0}, 1);
        chk("parity_err", parity_err, 1);
        chk("err_count", fifo_count, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_flags", {frame_err, parity_err, overrun}, 0);

        // clear coinciding with the CHECK cycle of a bad frame: set wins
        frame_in = {1'b0, 1'b0, 8'h33, 1'b0}; frame_done = 1'b1;
        tick();
        frame_done = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("set_wins", frame_err, 1);
        tick(); tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // fill past depth
        for (int i = 0; i < 5; i++) send(good(8'h10 + 8'(i)), 1);
        chk("fill_count", fifo_count, 4);
        chk("fill_overrun", overrun, 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", rx_valid, 1);
            chk("drain_data", rx_data, 8'h10 + 8'(i));
            tick();
        end
        rx_ready = 1'b0;
        chk("drain_empty", rx_valid, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // push and pop together while full
        for (int i = 0; i < 4; i++) send(good(8'h20 + 8'(i)), 1);
        chk("full_count", fifo_count, 4);
        frame_in = good(8'h24); frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        chk("pp_count", fifo_count, 4);
        chk("pp_overrun", overrun, 0);
        rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("pp_order", rx_data, 8'h20 + 8'(i));
            tick();
        end
        rx_ready = 1'b0;
        chk("pp_empty", fifo_count, 0);

        // long frame_done pulse gives a single push
        send(good(8'h77), 5);
        chk("long_count", fifo_count, 1);
        chk("long_data", rx_data, 8'h77);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;

        // frame already present at reset release is not captured
        frame_in = good(8'h66); frame_done = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (4) tick();
        chk("rel_no_push", fifo_count, 0);
        frame_done = 1'b0; tick();

        // asynchronous reset during CHECK with two bytes stored and a flag set
        send(good(8'h01), 1);
        send(good(8'h02), 1);
        send({1'b0, 1'b1, 8'h01, 1'b0}, 1);
        chk("pre_rst_count", fifo_count, 2);
        chk("pre_rst_flag", frame_err, 1);
        frame_in = good(8'h03); frame_done = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", rx_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_flags", {frame_err, parity_err, overrun}, 0);
        frame_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        send(good(8'h5A), 1);
        chk("post_rst_valid", rx_valid, 1);
        chk("post_rst_data", rx_data, 8'h5A);
        chk("post_rst_count", fifo_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side controller that sequences the serial-to-parallel frame receiver. It captures each completed 11-bit frame from the SIPO on the frame-done indication and checks start, stop and parity bits. Good frames go into a small show-ahead FIFO with a valid/ready interface toward the host logic. Framing, parity and overrun errors are kept as sticky flags.

Parameters:
DEPTH, 4, FIFO depth in bytes (power of 2, >=2)
PARITY_EN, 1, 1 = check frame_in[9] as parity; 0 = ignore bit 9
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
baud_clk  input  1  receiver clock (same clock as SIPO)
rst  input  1  asynchronous, active-high reset
frame_in  input  11  parallel frame from SIPO; [0] start, [8:1] data (bit1 = LSB), [9] parity, [10] stop
frame_done  input  1  SIPO received flag; high while a complete frame is presented on frame_in
rx_data  output  8  FIFO head byte; valid only when rx_valid=1
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts head byte when rx_valid&&rx_ready
fifo_count  output  $clog2(DEPTH+1)  bytes currently stored
frame_err  output  1  sticky: start!=0 or stop!=1 seen
parity_err  output  1  sticky: parity mismatch seen (PARITY_EN=1 only)
overrun  output  1  sticky: good frame dropped because FIFO full
err_clr  input  1  synchronous clear of all three sticky flags

Behaviour:
- Reset, asynchronous: state=IDLE, FIFO empty (pointers 0, fifo_count=0, rx_valid=0), rx_data=0, all error flags 0, frame_done history register=1 (no capture of a frame already present at reset release), frame latch=all 1s.
- Capture: rising edge of frame_done (current=1, registered previous=0).
- FSM states: IDLE, CHECK, STORE, WAIT_LOW.
  - IDLE: on rising edge in cycle N, latch frame_in and go to CHECK.
  - CHECK (N+1): frame_err cond = latch[0]!=0 || latch[10]!=1. Parity cond = PARITY_EN && (^latch[9:1] != PARITY_ODD). Any error: set the matching flag(s) at end of cycle, frame discarded, go to WAIT_LOW. Otherwise go to STORE.
  - STORE (N+2): push latch[8:1] at end of cycle if not full, or if full with a pop in the same cycle. Otherwise set overrun and drop. Then go to WAIT_LOW.
  - WAIT_LOW: stay until frame_done=0, then IDLE. One capture per assertion of frame_done.
- Latency: a good frame's edge at cycle N gives rx_valid=1 (if previously empty) and rx_data valid at cycle N+3.
- FIFO: show-ahead. rx_data = mem[rd_ptr] (registered read or mem output, either is allowed). Pop on rx_valid&&rx_ready. Pointers wrap modulo DEPTH.
  - fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Pop when empty is ignored.
- rx_ready is ignored when rx_valid=0. rx_data is held stable while rx_valid=1 and no pop occurs.
- Sticky flags: set by their condition, cleared by err_clr. If err_clr and a set condition occur in the same cycle, set wins.
- Rising edge of frame_done in CHECK/STORE/WAIT_LOW: ignored. This cannot occur at legal frame spacing (>=11 baud cycles).
- Reset mid-frame or mid-FSM: everything returns to reset values immediately and the in-flight frame is lost.

Test Plan:
- Good frame: frame_in=11'b1_0_10100101_0 (data 0xA5, even parity 0), frame_done pulsed high 1 cycle at cycle N, rx_ready=0 -> rx_valid=1, rx_data=8'hA5, fifo_count=1 at N+3; no flags set.
- Errors: stop=0, then start=1, then data 0x01 with parity 0 (even) -> frame_err=1 after the first two, parity_err=1 after the third, fifo_count stays 0. err_clr -> flags 0. err_clr in the same cycle as a new error -> flag stays 1.
- Overrun/fill: 5 good frames (0x10..0x14), rx_ready=0, DEPTH=4 -> fifo_count=4, overrun=1. Then drain with rx_ready=1 -> bytes read in order 0x10,0x11,0x12,0x13, rx_valid=0 after the 4th.
- Simultaneous push/pop at full: FIFO full, rx_ready=1 during a STORE cycle -> no overrun, fifo_count stays 4, new byte appears last in order.
- frame_done held high 5 cycles -> exactly one push. frame_done high at reset release -> no push.
- Async reset asserted in CHECK with 2 bytes stored -> rx_valid=0, fifo_count=0, flags 0, state IDLE. The next good frame is received normally.
